// File: rtl/gpio_bus_pkg.sv
// rtl/gpio_bus_pkg.sv - shared widths and FSM encoding for the gpio bus arbiter
package gpio_bus_pkg;

    localparam int GPIO_ADDR_W = 16;
    localparam int GPIO_DATA_W = 16;

    // One access at a time: arbitrate in IDLE, drive the slave in ACCESS,
    // report completion in DONE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } bus_state_t;

endpackage

// File: rtl/gpio_bus_arbiter_pick.sv
// rtl/gpio_bus_arbiter_pick.sv - combinational round-robin / fixed-priority request picker
//
// Ports:
//   req      in   N_REQ   request vector
//   ptr      in   IDX_W   index of the most recently served requester
//   any      out  1       at least one request present
//   win      out  N_REQ   one-hot winner (all zero when no request)
//   win_idx  out  IDX_W   binary index of the winner
module rr_arb_pick
    import gpio_bus_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter bit RR_EN = 1'b1,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [N_REQ-1:0] win,
    output logic [IDX_W-1:0] win_idx
);

    // Each requester gets a priority distance: in round-robin mode it is how
    // far past the pointer it sits (ptr+1 is distance 0), otherwise its own
    // index. The requester with the smallest distance wins.
    always_comb begin
        int best_d;
        int d;
        any     = |req;
        win     = '0;
        win_idx = '0;
        best_d  = N_REQ;
        d       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            if (RR_EN) begin
                d = (i - int'(ptr) - 1 + 2 * N_REQ) % N_REQ;
            end else begin
                d = i;
            end
            if (req[i] && (d < best_d)) begin
                best_d  = d;
                win     = '0;
                win[i]  = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// rtl/gpio_bus_arbiter.sv - shares the single gpio register port between N_REQ bus masters
//
// Ports:
//   clk        in   1              clock
//   rst        in   1              asynchronous active-high reset
//   req        in   N_REQ          per-master request
//   req_we     in   N_REQ          per-master write enable
//   req_addr   in   N_REQ*ADDR_W   per-master address, master i at [i*ADDR_W +: ADDR_W]
//   req_wdata  in   N_REQ*DATA_W   per-master write data, same packing
//   gnt        out  N_REQ          one-cycle pulse, request captured
//   done       out  N_REQ          one-cycle pulse, access complete and rdata valid
//   rdata      out  DATA_W         read data for the master flagged by done
//   s_addr     out  ADDR_W         slave address
//   s_wdata    out  DATA_W         slave write data
//   s_we       out  1              slave write enable
//   s_rdata    in   DATA_W         slave read data, combinational on s_addr
module gpio_bus_arbiter
    import gpio_bus_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter bit RR_EN  = 1'b1,
    parameter int ADDR_W = GPIO_ADDR_W,
    parameter int DATA_W = GPIO_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         req_we,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_wdata,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic [DATA_W-1:0]        rdata,
    output logic [ADDR_W-1:0]        s_addr,
    output logic [DATA_W-1:0]        s_wdata,
    output logic                     s_we,
    input  logic [DATA_W-1:0]        s_rdata
);

    localparam int IDX_W = $clog2(N_REQ);

    bus_state_t         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   widx_q, widx_d;
    logic [N_REQ-1:0]   gnt_d, done_d;
    logic [DATA_W-1:0]  rdata_d;
    logic [ADDR_W-1:0]  s_addr_d;
    logic [DATA_W-1:0]  s_wdata_d;
    logic               s_we_d;

    logic               pick_any;
    logic [N_REQ-1:0]   pick_win;
    logic [IDX_W-1:0]   pick_idx;

    rr_arb_pick #(
        .N_REQ (N_REQ),
        .RR_EN (RR_EN),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .any     (pick_any),
        .win     (pick_win),
        .win_idx (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        widx_d    = widx_q;
        gnt_d     = '0;
        done_d    = '0;
        rdata_d   = rdata;
        s_addr_d  = '0;
        s_wdata_d = '0;
        s_we_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    // The slave-side registers double as the latched copy of the
                    // winner's request, so later changes on req_* are ignored.
                    gnt_d  = pick_win;
                    widx_d = pick_idx;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (pick_win[i]) begin
                            s_addr_d  = req_addr[i*ADDR_W +: ADDR_W];
                            s_wdata_d = req_wdata[i*DATA_W +: DATA_W];
                            s_we_d    = req_we[i];
                        end
                    end
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // gnt is high for exactly this cycle and still names the winner.
                rdata_d = s_rdata;
                done_d  = gnt;
                ptr_d   = widx_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= IDX_W'(N_REQ - 1);
            widx_q  <= '0;
            gnt     <= '0;
            done    <= '0;
            rdata   <= '0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_we    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            widx_q  <= widx_d;
            gnt     <= gnt_d;
            done    <= done_d;
            rdata   <= rdata_d;
            s_addr  <= s_addr_d;
            s_wdata <= s_wdata_d;
            s_we    <= s_we_d;
        end
    end

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// tb/tb_gpio_bus_arbiter.sv - scoreboard bench for gpio_bus_arbiter
module tb_gpio_bus_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 16;

    typedef struct {
        int            m;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // round-robin DUT, three masters
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    gnt, done;
    logic [DW-1:0]   rdata, s_wdata, s_rdata;
    logic [AW-1:0]   s_addr;
    logic            s_we;

    gpio_bus_arbiter #(.N_REQ(N), .RR_EN(1'b1), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we), .s_rdata(s_rdata)
    );

    // fixed-priority DUT, two masters, slave echoes a scrambled address
    logic [1:0]      f_req = '0;
    logic [1:0]      f_req_we = '0;
    logic [2*AW-1:0] f_req_addr = '0;
    logic [2*DW-1:0] f_req_wdata = '0;
    logic [1:0]      f_gnt, f_done;
    logic [DW-1:0]   f_rdata, f_s_wdata, f_s_rdata;
    logic [AW-1:0]   f_s_addr;
    logic            f_s_we;

    assign f_s_rdata = f_s_addr ^ 16'h5A5A;

    gpio_bus_arbiter #(.N_REQ(2), .RR_EN(1'b0), .ADDR_W(AW), .DATA_W(DW)) dut_fp (
        .clk(clk), .rst(rst), .req(f_req), .req_we(f_req_we), .req_addr(f_req_addr),
        .req_wdata(f_req_wdata), .gnt(f_gnt), .done(f_done), .rdata(f_rdata),
        .s_addr(f_s_addr), .s_wdata(f_s_wdata), .s_we(f_s_we), .s_rdata(f_s_rdata)
    );

    // gpio register file stand-in
    logic [DW-1:0] mem [16];
    logic          mem_clr = 1'b1;
    assign s_rdata = mem[s_addr[3:0]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (s_we) begin
            mem[s_addr[3:0]] <= s_wdata;
        end
    end

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] ref_mem [16];
    logic          t_we    [N];
    logic [AW-1:0] t_addr  [N];
    logic [DW-1:0] t_wdata [N];
    int            last_served = N - 1;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    bit            spacing_en = 1'b0;
    int            last_gnt = -1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [N-1:0] onehot(input int m);
        return N'(1) << m;
    endfunction

    // Next master served: first requester after the last one served, cyclically.
    function automatic int pick_next(input logic [N-1:0] m, input int last);
        for (int k = 1; k <= N; k++) begin
            if (((m >> ((last + k) % N)) & N'(1)) != '0) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic set_txn(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        t_we[i] = we; t_addr[i] = a; t_wdata[i] = wd;
    endtask

    task automatic random_txn(input int i);
        set_txn(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
    endtask

    task automatic drive_txn(input int i);
        req_we[i] = t_we[i];
        req_addr[i*AW +: AW] = t_addr[i];
        req_wdata[i*DW +: DW] = t_wdata[i];
    endtask

    task automatic scramble(input int i);
        req_we[i] = ~req_we[i];
        req_addr[i*AW +: AW] = AW'($urandom);
        req_wdata[i*DW +: DW] = DW'($urandom);
    endtask

    task automatic push_txn(input int w);
        exp_t e;
        e.m = w; e.we = t_we[w]; e.addr = t_addr[w]; e.wdata = t_wdata[w];
        if (t_we[w]) begin
            ref_mem[t_addr[w][3:0]] = t_wdata[w];
            e.rd = '0;
        end else begin
            e.rd = ref_mem[t_addr[w][3:0]];
        end
        exp_q.push_back(e);
    endtask

    // Requests raised together and each held until its own done.
    task automatic plan(input logic [N-1:0] m);
        logic [N-1:0] rem;
        int w;
        rem = m;
        while (rem != '0) begin
            w = pick_next(rem, last_served);
            if (w < 0) break;
            push_txn(w);
            rem &= ~onehot(w);
            last_served = w;
        end
    endtask

    task automatic run_round(input logic [N-1:0] m);
        int n;
        plan(m);
        @(negedge clk);
        for (int i = 0; i < N; i++) if (m[i]) drive_txn(i);
        req = m;
        n = 0;
        while (req != '0 && n < 60) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) scramble(i);
                if (done[i]) req[i] = 1'b0;
            end
        end
        if (req != '0) begin
            checks++; errors++;
            $display("FAIL round_timeout req=%b want 000", req);
            req = '0;
            exp_q.delete();
        end
    endtask

    // Requests held continuously across several services.
    task automatic run_hold(input logic [N-1:0] m, input int cnt);
        int w, dn, n;
        for (int k = 0; k < cnt; k++) begin
            w = pick_next(m, last_served);
            push_txn(w);
            last_served = w;
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) if (m[i]) drive_txn(i);
        req = m;
        dn = 0; n = 0;
        while (dn < cnt && n < 100) begin
            @(negedge clk);
            n++;
            if (done != '0) begin
                dn++;
                if (dn == cnt) req = '0;
            end
        end
        if (dn != cnt) begin
            checks++; errors++;
            $display("FAIL hold_timeout done_count=%0d want %0d", dn, cnt);
            req = '0;
            exp_q.delete();
        end
    endtask

    // Monitor: every grant must match the scoreboard head, every done pops it.
    always @(negedge clk) begin
        if (!spacing_en) last_gnt = -1;
        if (!rst) begin
            if (gnt != '0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL gnt_unexpected got gnt=%b want none", gnt);
                end else if (gnt != onehot(exp_q[0].m) || s_we != exp_q[0].we ||
                             s_addr != exp_q[0].addr ||
                             (exp_q[0].we && s_wdata != exp_q[0].wdata)) begin
                    errors++;
                    $display("FAIL gnt_access got gnt=%b we=%b addr=%h wd=%h want gnt=%b we=%b addr=%h wd=%h",
                             gnt, s_we, s_addr, s_wdata, onehot(exp_q[0].m),
                             exp_q[0].we, exp_q[0].addr, exp_q[0].wdata);
                end
                if (spacing_en) begin
                    if (last_gnt >= 0) begin
                        checks++;
                        if (cyc - last_gnt != 3) begin
                            errors++;
                            $display("FAIL gnt_spacing got %0d cycles want 3", cyc - last_gnt);
                        end
                    end
                    last_gnt = cyc;
                end
            end else if (s_we) begin
                checks++; errors++;
                $display("FAIL slave_we_without_gnt got s_we=1 addr=%h want s_we=0", s_addr);
            end
            if (done != '0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected got done=%b want none", done);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (done != onehot(mon_e.m) || s_we || (!mon_e.we && rdata != mon_e.rd)) begin
                        errors++;
                        $display("FAIL done_data got done=%b rdata=%h s_we=%b want done=%b rdata=%h s_we=0 (we=%b)",
                                 done, rdata, s_we, onehot(mon_e.m), mon_e.rd, mon_e.we);
                    end
                end
            end
        end
    end

    initial begin
        int  n, g0;
        bit  seen1;
        exp_t e;

        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        for (int i = 0; i < N; i++) set_txn(i, 1'b0, '0, '0);

        repeat (3) @(negedge clk);
        checks++;
        if (gnt != '0 || done != '0 || s_we || rdata != '0 || s_addr != '0 || s_wdata != '0) begin
            errors++;
            $display("FAIL reset_outputs got gnt=%b done=%b s_we=%b rdata=%h s_addr=%h s_wdata=%h want all 0",
                     gnt, done, s_we, rdata, s_addr, s_wdata);
        end
        checks++;
        if (f_gnt != '0 || f_done != '0 || f_s_we || f_rdata != '0 || f_s_addr != '0) begin
            errors++;
            $display("FAIL fp_reset_outputs got gnt=%b done=%b s_we=%b rdata=%h s_addr=%h want all 0",
                     f_gnt, f_done, f_s_we, f_rdata, f_s_addr);
        end
        mem_clr = 1'b0;
        rst = 1'b0;

        // write by M1, read back by M0, then a three-way collision on one address
        set_txn(1, 1'b1, 16'h0004, 16'h00F0);
        run_round(3'b010);
        set_txn(0, 1'b0, 16'h0004, 16'h0000);
        run_round(3'b001);
        set_txn(0, 1'b0, 16'h0004, 16'h0000);
        set_txn(1, 1'b1, 16'h0004, 16'h1234);
        set_txn(2, 1'b0, 16'h0004, 16'h0000);
        run_round(3'b111);

        repeat (40) begin
            for (int i = 0; i < N; i++) random_txn(i);
            run_round(N'($urandom_range(1, (1 << N) - 1)));
        end

        // M1 pulses req only while M0 is being served: must never be granted
        set_txn(0, 1'b0, 16'h0003, 16'h0000);
        set_txn(1, 1'b1, 16'h0003, 16'hDEAD);
        plan(3'b001);
        @(negedge clk);
        drive_txn(0); drive_txn(1);
        req = 3'b001;
        seen1 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (gnt[0]) req[1] = 1'b1;
            if (done[0]) req = '0;
            if (gnt[1] || (s_we && s_addr == 16'h0003)) seen1 = 1'b1;
        end
        checks++;
        if (seen1 || req != '0 || mem[3] != ref_mem[3]) begin
            errors++;
            $display("FAIL withdraw got seen_m1=%0d req=%b mem3=%h want 0 000 %h",
                     seen1, req, mem[3], ref_mem[3]);
            req = '0;
        end

        // reset in the middle of a write
        set_txn(0, 1'b1, 16'h0005, 16'hBEEF);
        e.m = 0; e.we = 1'b1; e.addr = 16'h0005; e.wdata = 16'hBEEF; e.rd = '0;
        exp_q.push_back(e);
        @(negedge clk);
        drive_txn(0);
        req = 3'b001;
        n = 0;
        while (!gnt[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!gnt[0] || !s_we) begin
            errors++;
            $display("FAIL abort_setup got gnt=%b s_we=%b want 001 1", gnt, s_we);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (s_we || gnt != '0 || done != '0) begin
            errors++;
            $display("FAIL abort_async got s_we=%b gnt=%b done=%b want 0 000 000", s_we, gnt, done);
        end
        req = '0;
        exp_q.delete();
        last_served = N - 1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (mem[5] != ref_mem[5]) begin
            errors++;
            $display("FAIL abort_no_write got mem5=%h want %h", mem[5], ref_mem[5]);
        end

        // both held from reset: 0,1,0,1 with a grant every three cycles
        set_txn(0, 1'b0, 16'h0004, 16'h0000);
        set_txn(1, 1'b0, 16'h0005, 16'h0000);
        spacing_en = 1'b1;
        run_hold(3'b011, 4);
        spacing_en = 1'b0;

        // fixed priority: M0 always wins while it requests
        f_req_addr = {16'h0022, 16'h0011};
        @(negedge clk);
        f_req = 2'b11;
        g0 = 0; seen1 = 1'b0; n = 0;
        while (!seen1 && n < 60) begin
            @(negedge clk);
            n++;
            if (f_gnt != '0) begin
                checks++;
                if (g0 < 3) begin
                    if (f_gnt != 2'b01) begin
                        errors++;
                        $display("FAIL fp_gnt_m0 got %b want 01", f_gnt);
                    end
                    if (f_gnt[1]) seen1 = 1'b1;
                    g0++;
                end else begin
                    if (f_gnt != 2'b10) begin
                        errors++;
                        $display("FAIL fp_gnt_m1 got %b want 10", f_gnt);
                    end
                    seen1 = 1'b1;
                end
            end
            if (f_done[0]) begin
                checks++;
                if (f_rdata != (16'h0011 ^ 16'h5A5A)) begin
                    errors++;
                    $display("FAIL fp_rdata0 got %h want %h", f_rdata, 16'h0011 ^ 16'h5A5A);
                end
                if (g0 == 3) f_req[0] = 1'b0;
            end
        end
        checks++;
        if (!seen1) begin
            errors++;
            $display("FAIL fp_timeout got no grant to M1 want 10");
        end
        n = 0;
        while (!f_done[1] && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!f_done[1] || f_rdata != (16'h0022 ^ 16'h5A5A)) begin
            errors++;
            $display("FAIL fp_done1 got done=%b rdata=%h want 10 %h", f_done, f_rdata, 16'h0022 ^ 16'h5A5A);
        end
        f_req = '0;

        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
